pc_gen_unit: RTL and testbench

- Parametrised next-generation program-counter unit for the CPU fetch stage.
- Holds the fetch PC and computes the next PC from the following sources:
  - sequential increment,
  - branch and jump redirects,
  - a trap vector,
  - an internal return-address stack (RAS) for call/return.
- Adds boot sequencing, stall, and halt/resume modes.
- Drives instruction-memory address and fetch-valid to the fetch stage.

---
 rtl/pc_gen_unit_pkg.sv | 29 ++
 rtl/pc_gen_unit_if.sv | 38 +++
 rtl/pc_gen_unit_ras_stack.sv | 56 +++++
 rtl/pc_gen_unit.sv | 128 ++++++++++++
 tb/tb_pc_gen_unit.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared types for the program-counter unit: control state and
//            next-PC source select.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Control state of the PC unit.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Source of the next fetch PC, listed in decreasing priority.
  typedef enum logic [2:0] {
    SEL_TRAP = 3'd0,
    SEL_CALL = 3'd1,
    SEL_RET  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_JMP  = 3'd4,
    SEL_HOLD = 3'd5,
    SEL_SEQ  = 3'd6
  } sel_t;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_gen_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_if
// Purpose  : Control inputs and fetch outputs of the PC unit. The master side
//            drives redirects/modes; the slave side is the PC unit itself.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             halt;
  logic             resume;
  logic             trap;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] pc_addr;
  logic             pc_valid;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, halt, resume, trap, branch_taken, branch_target,
           jump, call, ret, jump_target,
    input  pc_addr, pc_valid, ras_empty, ras_full
  );

  modport slave (
    input  stall, halt, resume, trap, branch_taken, branch_target,
           jump, call, ret, jump_target,
    output pc_addr, pc_valid, ras_empty, ras_full
  );
endinterface : pc_gen_if
`default_nettype wire

// File: rtl/pc_gen_unit_ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Purpose  : Circular return-address stack. Pushing when full overwrites the
//            oldest entry and keeps the count saturated; popping walks the top
//            pointer back, so the newest surviving entries come out LIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;      // next free slot; newest entry sits at ptr-1
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] count;

  assign ptr_dec  = ptr - PTR_W'(1);
  assign top_data = mem[ptr_dec];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(RAS_DEPTH));

  // Pointer and occupancy; push wins over pop, pop on empty is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage; a push into a full stack lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_unit
// Purpose  : Fetch program counter with sequential step, branch/jump/trap
//            redirects, call/return stack, boot cycle, stall and halt/resume.
//            pc_addr and pc_valid come straight from flops.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080),
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  import pc_pkg::*;

  state_t           state;
  state_t           next_state;
  sel_t             sel;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] ras_top;
  logic             valid;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_empty;
  logic             ras_full;

  // Wraps modulo 2^WIDTH by truncation.
  assign seq_pc = pc + WIDTH'(STEP);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Next-state and next-PC source selection by strict priority.
  always_comb begin
    next_state = state;
    sel        = SEL_HOLD;
    case (state)
      BOOT: begin
        next_state = RUN;
      end
      RUN: begin
        if (bus.trap)              sel = SEL_TRAP;
        else if (bus.call)         sel = SEL_CALL;
        else if (bus.ret)          sel = SEL_RET;
        else if (bus.branch_taken) sel = SEL_BR;
        else if (bus.jump)         sel = SEL_JMP;
        else if (bus.halt) begin
          sel        = SEL_HOLD;
          next_state = HALT;
        end
        else if (bus.stall)        sel = SEL_HOLD;
        else                       sel = SEL_SEQ;
      end
      HALT: begin
        if (bus.trap) begin
          sel        = SEL_TRAP;
          next_state = RUN;
        end else if (bus.resume) begin
          next_state = RUN;
        end
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  // Next-PC mux and stack control driven by the selected source.
  always_comb begin
    next_pc  = pc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (sel)
      SEL_TRAP: next_pc = TRAP_VECTOR;
      SEL_CALL: begin
        next_pc  = bus.jump_target;
        ras_push = 1'b1;
      end
      SEL_RET: begin
        ras_pop = 1'b1;
        next_pc = ras_empty ? bus.jump_target : ras_top;
      end
      SEL_BR:   next_pc = bus.branch_target;
      SEL_JMP:  next_pc = bus.jump_target;
      SEL_SEQ:  next_pc = seq_pc;
      default:  next_pc = pc;
    endcase
  end

  // State, PC and valid registers; valid follows the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      valid <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      valid <= (next_state == RUN);
    end
  end

  assign bus.pc_addr   = pc;
  assign bus.pc_valid  = valid;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;

endmodule : pc_gen_unit
`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen_unit
// Purpose  : Self-checking bench for pc_gen_unit: directed scenarios plus a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen_unit;

  localparam int          W  = 32;
  localparam int          D  = 4;
  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h80;
  localparam int          M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_gen_if #(.WIDTH(W)) bus();

  pc_gen_unit #(
    .WIDTH(W), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .STEP(4), .RAS_DEPTH(D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int          m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ras[$];

  logic [34:0] dut_vec;
  assign dut_vec = {bus.pc_addr, bus.pc_valid, bus.ras_empty, bus.ras_full};

  function automatic logic [34:0] exp_vec();
    return {m_pc, m_valid, (m_ras.size() == 0), (m_ras.size() == D)};
  endfunction

  task automatic m_reset();
    m_state = M_BOOT;
    m_pc    = RV;
    m_valid = 1'b0;
    m_ras.delete();
  endtask

  // One clock of the architectural rules, applied to the current inputs.
  task automatic m_update();
    if (m_state == M_BOOT) begin
      m_state = M_RUN;
      m_valid = 1'b1;
    end else if (m_state == M_RUN) begin
      if (bus.trap) m_pc = TV;
      else if (bus.call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > D) void'(m_ras.pop_front());
        m_pc = bus.jump_target;
      end else if (bus.ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else m_pc = bus.jump_target;
      end
      else if (bus.branch_taken) m_pc = bus.branch_target;
      else if (bus.jump) m_pc = bus.jump_target;
      else if (bus.halt) begin
        m_state = M_HALT;
        m_valid = 1'b0;
      end
      else if (!bus.stall) m_pc = m_pc + 32'd4;
    end else begin
      if (bus.trap) begin
        m_pc    = TV;
        m_state = M_RUN;
        m_valid = 1'b1;
      end else if (bus.resume) begin
        m_state = M_RUN;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic clr();
    bus.stall = 0; bus.halt = 0; bus.resume = 0; bus.trap = 0;
    bus.branch_taken = 0; bus.branch_target = '0; bus.jump = 0;
    bus.call = 0; bus.ret = 0; bus.jump_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    clr(); bus.jump = 1; bus.jump_target = target;
    tick();
    clr();
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    n_vec++;
    if (dut_vec !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_state: got %h want %h", dut_vec, {32'h0, 3'b010});
    end
    rst = 1'b0;
    n_vec++;
    if (bus.pc_valid !== 1'b0) begin
      n_err++; $display("FAIL boot_valid: got %b want 0", bus.pc_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (bus.pc_addr !== 32'(i * 4) || bus.pc_valid !== 1'b1 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL boot_seq[%0d]: got %h want pc %h valid 1", i, dut_vec, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall_branch();
    goto_pc(32'h10);
    bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (bus.pc_addr !== 32'h10 || bus.pc_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d]: got pc %h valid %b want 10/1", i, bus.pc_addr, bus.pc_valid);
      end
    end
    bus.branch_taken = 1; bus.branch_target = 32'h200;
    tick();
    n_vec++;
    if (bus.pc_addr !== 32'h200 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL branch_over_stall: got pc %h want 200", bus.pc_addr);
    end
    clr();
  endtask

  task automatic test_call_ret();
    logic [31:0] exp_pc [6];
    exp_pc = '{32'h100, 32'h104, 32'h300, 32'h108, 32'h24, 32'h500};
    goto_pc(32'h20);
    for (int i = 0; i < 6; i++) begin
      clr();
      case (i)
        0: begin bus.call = 1; bus.jump_target = 32'h100; end
        2: begin bus.call = 1; bus.jump_target = 32'h300; bus.ret = 1; end
        3, 4: bus.ret = 1;
        5: begin bus.ret = 1; bus.jump_target = 32'h500; end
        default: ;
      endcase
      tick();
      n_vec++;
      if (bus.pc_addr !== exp_pc[i] || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL call_ret[%0d]: got %h want pc %h model %h", i, dut_vec, exp_pc[i], exp_vec());
      end
    end
    n_vec++;
    if (bus.ras_empty !== 1'b1) begin
      n_err++; $display("FAIL ret_empty_flag: got %b want 1", bus.ras_empty);
    end
    clr();
  endtask

  task automatic test_ras_overflow();
    for (int k = 0; k < 5; k++) begin
      goto_pc(32'(k * 16));
      bus.call = 1; bus.jump_target = 32'h1000;
      tick();
    end
    n_vec++;
    if (bus.ras_full !== 1'b1 || bus.ras_empty !== 1'b0) begin
      n_err++; $display("FAIL ras_full: got full %b empty %b want 1/0", bus.ras_full, bus.ras_empty);
    end
    clr(); bus.ret = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (bus.pc_addr !== 32'(32'h44 - i * 16) || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL ras_pop[%0d]: got pc %h want %h", i, bus.pc_addr, 32'(32'h44 - i * 16));
      end
    end
    n_vec++;
    if (bus.ras_empty !== 1'b1) begin
      n_err++; $display("FAIL ras_drained: got empty %b want 1", bus.ras_empty);
    end
    clr();
  endtask

  task automatic test_halt();
    goto_pc(32'h40);
    bus.halt = 1;
    tick();
    n_vec++;
    if (bus.pc_addr !== 32'h40 || bus.pc_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_enter: got pc %h valid %b want 40/0", bus.pc_addr, bus.pc_valid);
    end
    clr(); bus.jump = 1; bus.jump_target = 32'h998; bus.call = 1; bus.stall = 1;
    tick();
    n_vec++;
    if (bus.pc_addr !== 32'h40 || bus.pc_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL halt_ignore: got pc %h valid %b want 40/0", bus.pc_addr, bus.pc_valid);
    end
    clr(); bus.resume = 1;
    tick();
    n_vec++;
    if (bus.pc_addr !== 32'h40 || bus.pc_valid !== 1'b1) begin
      n_err++; $display("FAIL resume: got pc %h valid %b want 40/1", bus.pc_addr, bus.pc_valid);
    end
    clr(); bus.halt = 1;
    tick();
    clr(); bus.trap = 1;
    tick();
    n_vec++;
    if (bus.pc_addr !== 32'h80 || bus.pc_valid !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL halt_trap: got pc %h valid %b want 80/1", bus.pc_addr, bus.pc_valid);
    end
    clr();
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    tick();
    n_vec++;
    if (bus.pc_addr !== 32'h0 || bus.pc_valid !== 1'b1) begin
      n_err++; $display("FAIL pc_wrap: got pc %h want 00000000", bus.pc_addr);
    end
  endtask

  task automatic test_reset_mid_call();
    goto_pc(32'h20);
    bus.call = 1; bus.jump_target = 32'h100;
    tick();
    bus.jump_target = 32'h200;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    n_vec++;
    if (dut_vec !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_call: got %h want %h", dut_vec, {32'h0, 3'b010});
    end
    clr();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    n_vec++;
    if (bus.pc_addr !== 32'h0 || bus.pc_valid !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reboot: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bus.trap          = ($urandom_range(99) < 3);
      bus.call          = ($urandom_range(99) < 10);
      bus.ret           = ($urandom_range(99) < 10);
      bus.branch_taken  = ($urandom_range(99) < 8);
      bus.jump          = ($urandom_range(99) < 6);
      bus.halt          = ($urandom_range(99) < 5);
      bus.resume        = ($urandom_range(99) < 25);
      bus.stall         = ($urandom_range(99) < 15);
      bus.branch_target = {$urandom_range(32'hFFFF), 2'b00};
      bus.jump_target   = {$urandom_range(32'hFFFF), 2'b00};
      tick();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    clr();
  endtask

  initial begin
    clr();
    m_reset();
    test_reset();
    test_stall_branch();
    test_call_ret();
    test_ras_overflow();
    test_halt();
    test_wrap();
    test_reset_mid_call();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pc_gen_unit
`default_nettype wire
